rom_loader_sequencer: RTL and testbench



---
 rtl/rom_loader_pkg.sv | 20 ++
 rtl/rom_loader_sequencer_buffer.sv | 40 ++++
 rtl/rom_loader_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rom_loader_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// ----------------------------------------------------------------------------
// rom_loader_pkg
//   Shared definitions for the ROM loader / run sequencer that feeds the cpu
//   core: the sequencer state enum and default buffer geometry.
// ----------------------------------------------------------------------------
package rom_loader_pkg;

    // Default program buffer depth (bytes) and captured core memory width.
    localparam int ROM_BYTES_DEF     = 128;
    localparam int MEM_OUT_BYTES_DEF = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage : rom_loader_pkg

// File: rtl/rom_loader_sequencer_buffer.sv
// ----------------------------------------------------------------------------
// rom_byte_buffer
//   Byte-addressed program buffer presented to the core as one flattened bus.
//   Byte i drives rom[8*i +: 8]. A clear strobe zeroes the whole buffer so
//   bytes that a load never reaches read as 0 (NOP to the core).
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (clears buffer)
//   clr      in   synchronous clear strobe (start of a new load)
//   wr_en    in   write strobe
//   wr_addr  in   byte address
//   wr_data  in   byte to store
//   rom      out  flattened buffer contents
// ----------------------------------------------------------------------------
module rom_byte_buffer #(
    parameter int ROM_BYTES = 128,
    parameter int ADDR_W    = $clog2(ROM_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [7:0]             wr_data,
    output logic [8*ROM_BYTES-1:0] rom
);

    // NOTE: this storage is a flop array, not a RAM macro, because the core
    // must see all-zero contents straight out of reset; resetting it is
    // therefore both legal and required.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rom <= '0;
        end else if (wr_en) begin
            rom[8*wr_addr +: 8] <= wr_data;
        end
    end

endmodule : rom_byte_buffer

// File: rtl/rom_loader_sequencer.sv
// ----------------------------------------------------------------------------
// rom_loader_sequencer
//   Front-end of the cpu core. Assembles a byte stream into the core's ROM
//   bus while holding the core in reset, releases the core for RUN_CYCLES
//   clock edges, then snapshots the core's memory output as the result.
//
//   Optional feature (macro ROM_LOADER_CHECKSUM_EN): the byte accepted with
//   in_last is an 8-bit wrapping checksum of the stored bytes instead of
//   program data. A mismatch, or a load cut off at ROM_BYTES without
//   in_last, skips the run and raises csum_err until the next start.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse; honoured in IDLE or DONE only
//   in_valid/ready  byte-stream handshake (ready high only while loading)
//   in_data/in_last program byte / final-byte marker
//   rom             flattened program buffer to the core
//   cpu_rst         registered reset to the core (low only while running)
//   memory_out_in   core memory output
//   result          captured snapshot; result_valid qualifies it
//   truncated       sticky: load ended at ROM_BYTES without in_last
//   busy            high while loading, running or capturing
//   csum_err        checksum failure (only with ROM_LOADER_CHECKSUM_EN)
// ----------------------------------------------------------------------------
module rom_loader_sequencer
    import rom_loader_pkg::*;
#(
    parameter int ROM_BYTES     = ROM_BYTES_DEF,
    parameter int MEM_OUT_BYTES = MEM_OUT_BYTES_DEF,
    parameter int RUN_CYCLES    = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic                       in_last,
    output logic [8*ROM_BYTES-1:0]     rom,
    output logic                       cpu_rst,
    input  logic [8*MEM_OUT_BYTES-1:0] memory_out_in,
    output logic [8*MEM_OUT_BYTES-1:0] result,
    output logic                       result_valid,
`ifdef ROM_LOADER_CHECKSUM_EN
    output logic                       csum_err,
`endif
    output logic                       truncated,
    output logic                       busy
);

    localparam int               PTR_W     = $clog2(ROM_BYTES);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(ROM_BYTES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    state_e           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] run_cnt;

    logic handshake;
    logic load_done;
    logic restart;
    logic buf_wr;

    // in_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign handshake = in_valid & in_ready;
    // The ROM_BYTES-th byte ends the load even without in_last, so wr_ptr
    // never has to wrap.
    assign load_done = handshake & (in_last | (wr_ptr == LAST_SLOT));
    assign restart   = start & ((state == IDLE) | (state == DONE));

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] csum_acc;
    logic       csum_ok;

    // The in_last byte carries the checksum and is never stored; a load that
    // ends without in_last has no checksum and always fails.
    assign buf_wr  = handshake & ~in_last;
    assign csum_ok = in_last & (csum_acc == in_data);
`else
    assign buf_wr  = handshake;
`endif

    rom_byte_buffer #(
        .ROM_BYTES (ROM_BYTES),
        .ADDR_W    (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (restart),
        .wr_en   (buf_wr),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rom     (rom)
    );

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every branch below sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            run_cnt      <= '0;
            cpu_rst      <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
            truncated    <= 1'b0;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_acc     <= '0;
            csum_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        wr_ptr       <= '0;
                        result_valid <= 1'b0;
                        truncated    <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_acc     <= '0;
                        csum_err     <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    if (handshake) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        if (buf_wr) begin
                            csum_acc <= csum_acc + in_data;
                        end
`endif
                        if (load_done) begin
                            in_ready  <= 1'b0;
                            truncated <= ~in_last;
`ifdef ROM_LOADER_CHECKSUM_EN
                            if (csum_ok) begin
                                state   <= RUN;
                                run_cnt <= '0;
                                cpu_rst <= 1'b0;
                            end else begin
                                state    <= DONE;
                                csum_err <= 1'b1;
                                busy     <= 1'b0;
                            end
`else
                            state   <= RUN;
                            run_cnt <= '0;
                            cpu_rst <= 1'b0;
`endif
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end

                // cpu_rst is low for run_cnt = 0..RUN_CYCLES-1, so the core
                // retires exactly RUN_CYCLES edges.
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state   <= CAPTURE;
                        cpu_rst <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end

                // The core clears on this same edge because cpu_rst is high,
                // so memory_out_in still holds the post-run value here.
                CAPTURE: begin
                    result       <= memory_out_in;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : rom_loader_sequencer

// File: tb/tb_rom_loader_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rom_loader_sequencer
//   Self-checking bench. A stand-in core copies rom byte k into memory_out
//   byte k on its k-th retired edge (clearing whenever cpu_rst is high), so
//   the captured result exposes how many edges the core actually ran.
// ----------------------------------------------------------------------------
module tb_rom_loader_sequencer;

    localparam int ROM_BYTES     = 128;
    localparam int MEM_OUT_BYTES = 24;
    localparam int RUN_CYCLES    = 5;
    localparam int CNT_W         = 16;

    typedef logic [7:0] byte_q_t[$];

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 in_data;
    logic                       in_last;
    logic [8*ROM_BYTES-1:0]     rom;
    logic                       cpu_rst;
    logic [8*MEM_OUT_BYTES-1:0] memory_out_in;
    logic [8*MEM_OUT_BYTES-1:0] result;
    logic                       result_valid;
    logic                       truncated;
    logic                       busy;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic                       csum_err;
`endif

    rom_loader_sequencer #(
        .ROM_BYTES     (ROM_BYTES),
        .MEM_OUT_BYTES (MEM_OUT_BYTES),
        .RUN_CYCLES    (RUN_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .rom           (rom),
        .cpu_rst       (cpu_rst),
        .memory_out_in (memory_out_in),
        .result        (result),
        .result_valid  (result_valid),
`ifdef ROM_LOADER_CHECKSUM_EN
        .csum_err      (csum_err),
`endif
        .truncated     (truncated),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ---------------- stand-in core ----------------
    logic [8*MEM_OUT_BYTES-1:0] core_mem = '0;
    int                         core_pc  = 0;
    assign memory_out_in = core_mem;

    always @(posedge clk) begin
        if (cpu_rst === 1'b1) begin
            core_mem <= '0;
            core_pc  <= 0;
        end else if (cpu_rst === 1'b0) begin
            if (core_pc < MEM_OUT_BYTES) core_mem[8*core_pc +: 8] <= rom[8*core_pc +: 8];
            core_pc <= core_pc + 1;
        end
    end

    // ---------------- counters and check helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Abstract view: a load is in progress, some number of core edges remain,
    // or a capture is pending; otherwise the block waits for start.
    logic [7:0] m_rom[ROM_BYTES];
    logic [7:0] m_res[MEM_OUT_BYTES];
    int         m_wp       = 0;
    bit         m_loading  = 0;
    int         m_run_left = 0;
    bit         m_cap      = 0;
    bit         m_rv       = 0;
    bit         m_trunc    = 0;
    bit         m_csum_err = 0;
    logic [7:0] m_sum      = 0;
    bit         m_fin;
    bit         m_ok;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_rom[i]) m_rom[i] = 8'h00;
            foreach (m_res[i]) m_res[i] = 8'h00;
            m_wp = 0; m_loading = 0; m_run_left = 0; m_cap = 0;
            m_rv = 0; m_trunc = 0; m_sum = 0; m_csum_err = 0;
        end else if (m_loading) begin
            if (in_valid) begin
                m_fin = in_last || (m_wp == ROM_BYTES - 1);
`ifdef ROM_LOADER_CHECKSUM_EN
                m_ok = in_last && (m_sum == in_data);
                if (!in_last) begin
                    m_rom[m_wp] = in_data;
                    m_sum       = m_sum + in_data;
                end
`else
                m_ok = 1;
                m_rom[m_wp] = in_data;
`endif
                m_wp++;
                if (m_fin) begin
                    m_loading = 0;
                    m_trunc   = !in_last;
                    if (m_ok) m_run_left = RUN_CYCLES;
                    else      m_csum_err = 1;
                end
            end
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) m_cap = 1;
        end else if (m_cap) begin
            m_cap = 0;
            m_rv  = 1;
            foreach (m_res[i]) m_res[i] = (i < RUN_CYCLES) ? m_rom[i] : 8'h00;
        end else if (start) begin
            m_loading = 1;
            foreach (m_rom[i]) m_rom[i] = 8'h00;
            m_wp = 0; m_rv = 0; m_trunc = 0; m_sum = 0; m_csum_err = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit                         chk_en = 0;
    logic [8*ROM_BYTES-1:0]     exp_rom;
    logic [8*MEM_OUT_BYTES-1:0] exp_res;
    logic [5:0]                 exp_ctrl;
    logic [5:0]                 act_ctrl;

    always @(negedge clk) begin
        if (chk_en) begin
            foreach (m_rom[i]) exp_rom[8*i +: 8] = m_rom[i];
            foreach (m_res[i]) exp_res[8*i +: 8] = m_res[i];
            exp_ctrl = {m_loading, (m_run_left == 0), (m_loading || m_run_left > 0 || m_cap),
                        m_rv, m_trunc, m_csum_err};
`ifdef ROM_LOADER_CHECKSUM_EN
            act_ctrl = {in_ready, cpu_rst, busy, result_valid, truncated, csum_err};
`else
            act_ctrl = {in_ready, cpu_rst, busy, result_valid, truncated, 1'b0};
`endif
            check("ctrl{rdy,cpu_rst,busy,rv,trunc,cerr}", 256'(act_ctrl), 256'(exp_ctrl));
            for (int c = 0; c < 4; c++) check("rom", rom[256*c +: 256], exp_rom[256*c +: 256]);
            check("result", 256'(result), 256'(exp_res));
        end
    end

    // ---------------- monitors ----------------
    int hs_count  = 0;
    int low_len   = 0;
    int last_low  = 0;
    int low_runs  = 0;

    always @(posedge clk) if (in_valid === 1'b1 && in_ready === 1'b1) hs_count++;

    always @(negedge clk) begin
        if (rst) begin
            low_len = 0;
        end else if (cpu_rst === 1'b0) begin
            low_len++;
        end else if (low_len > 0) begin
            last_low = low_len;
            low_runs++;
            low_len  = 0;
        end
    end

    logic done_flag;
`ifdef ROM_LOADER_CHECKSUM_EN
    assign done_flag = result_valid | csum_err;
`else
    assign done_flag = result_valid;
`endif

    // ---------------- stimulus tasks ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Drive bytes at negedges; a byte is taken at the next posedge when
    // in_ready is already high. gappy drops in_valid for a cycle between
    // bytes and puts noise on in_last/in_data while it is low.
    task automatic send(input byte_q_t q, input bit mark_last, input bit gappy);
        for (int i = 0; i < q.size(); i++) begin
            int waited = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = mark_last && (i == q.size() - 1);
            while (in_ready !== 1'b1) begin
                if (waited > 20) begin
                    timeout("send_ready");
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                waited++;
            end
            if (gappy) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_flag !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > bound) begin
                timeout("wait_done");
                return;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    byte_q_t q;
    int      hs0;
    int      lr0;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cpu_rst", 256'(cpu_rst), 256'(1));
        check("reset_rom_zero", 256'(|rom), 256'(0));
        check("reset_result_valid", 256'(result_valid), 256'(0));
        check("reset_in_ready", 256'(in_ready), 256'(0));
        chk_en = 1;
        rst    = 1'b0;

`ifndef ROM_LOADER_CHECKSUM_EN
        // Directed program; stand-in core copies RUN_CYCLES=5 bytes.
        q = '{8'h09, 8'h2A, 8'h31, 8'hE8};
        pulse_start();
        send(q, 1, 0);
        wait_done(50);
        check("vec_cpu_rst_low_len", 256'(last_low), 256'(5));
        check("vec_result_lo", 256'(result[31:0]), 256'(32'hE831_2A09));
        check("vec_result_hi_zero", 256'(result[191:32]), 256'(0));
        check("vec_result_valid", 256'(result_valid), 256'(1));
        check("vec_truncated", 256'(truncated), 256'(0));

        // Full buffer without in_last: exits on byte 128, byte 129 refused.
        q.delete();
        for (int i = 0; i < ROM_BYTES; i++) q.push_back(8'($urandom));
        hs0 = hs_count;
        pulse_start();
        send(q, 0, 0);
        check("trunc_flag", 256'(truncated), 256'(1));
        @(negedge clk) begin in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; end
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("trunc_handshakes", 256'(hs_count - hs0), 256'(128));
        check("trunc_in_ready_low", 256'(in_ready), 256'(0));
        wait_done(50);
        check("trunc_after_done", 256'(truncated), 256'(1));

        // Toggled in_valid: bytes land at 0..3 in order, no duplicates.
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        hs0 = hs_count;
        pulse_start();
        send(q, 1, 1);
        wait_done(50);
        check("toggle_rom", 256'(rom[39:0]), 256'(40'h00_4433_2211));
        check("toggle_handshakes", 256'(hs_count - hs0), 256'(4));

        // Reset in the third RUN cycle aborts; next load completes.
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pulse_start();
        send(q, 1, 0);
        begin
            int n = 0;
            while (cpu_rst !== 1'b0 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) timeout("wait_run");
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_cpu_rst", 256'(cpu_rst), 256'(1));
        check("abort_result_valid", 256'(result_valid), 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        q = '{8'hA1, 8'hB2, 8'hC3};
        pulse_start();
        send(q, 1, 0);
        wait_done(50);
        check("after_abort_result", 256'(result[23:0]), 256'(24'hC3_B2A1));
`else
        // Checksum good: 0x09 + 0x2A = 0x33; checksum byte is not stored.
        q = '{8'h09, 8'h2A, 8'h33};
        pulse_start();
        send(q, 1, 0);
        wait_done(50);
        check("csum_ok_result_valid", 256'(result_valid), 256'(1));
        check("csum_ok_err", 256'(csum_err), 256'(0));
        check("csum_ok_result", 256'(result[23:0]), 256'(24'h00_2A09));
        check("csum_ok_low_len", 256'(last_low), 256'(5));
        // Checksum bad: no run at all.
        lr0 = low_runs;
        q = '{8'h09, 8'h2A, 8'h34};
        pulse_start();
        send(q, 1, 0);
        wait_done(50);
        repeat (3) @(negedge clk);
        check("csum_bad_err", 256'(csum_err), 256'(1));
        check("csum_bad_result_valid", 256'(result_valid), 256'(0));
        check("csum_bad_no_run", 256'(low_runs - lr0), 256'(0));
`endif

        // Randomised loads with gaps, ignored start/in_valid noise while busy
        // and while done; the per-cycle compare carries the checking.
        for (int t = 0; t < 12; t++) begin
            int len = $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            pulse_start();
            send(q, 1, 1'($urandom_range(0, 1)));
            repeat (2) begin
                @(negedge clk);
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            @(negedge clk) begin start = 1'b0; in_valid = 1'b0; end
            wait_done(60);
            @(negedge clk) begin in_valid = 1'b1; in_data = 8'($urandom); end
            @(negedge clk) in_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rom_loader_sequencer
